// File: rtl/mem_action_responder_if.sv
// mem_action_responder_if: request/response bundle between a memory initiator and the responder
interface mem_action_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wren;
  logic [7:0]  req_mask;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        resp_dexc;
  modport master (
    output req_valid, req_wren, req_mask, req_addr, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_dexc
  );
  modport slave (
    input  req_valid, req_wren, req_mask, req_addr, req_data, resp_ready,
    output req_ready, resp_valid, resp_data, resp_dexc
  );
endinterface

// File: rtl/mem_action_responder.sv
// mem_action_responder: byte-maskable 64-bit word memory with one outstanding request, fixed latency and response backpressure
module mem_action_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_action_responder_if.slave  bus
);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            lat_wren;
  logic [7:0]      lat_mask;
  logic [63:0]     lat_addr, lat_data;
  logic [63:0]     mem [DEPTH];
  logic            take, done, a_wren, fault;
  logic [7:0]      a_mask;
  logic [63:0]     a_addr, a_data, rd_word, wr_word, resp_data_q;
  logic [IW-1:0]   idx;
  logic            resp_dexc_q;
  // With LATENCY==1 the access completes on the accept edge, so it must use the live request fields
  always_comb begin
    take     = state == IDLE && bus.req_valid;
    done     = (take && LATENCY == 1) || (state == BUSY && cnt == CW'(0));
    a_wren   = state == IDLE ? bus.req_wren : lat_wren;
    a_mask   = state == IDLE ? bus.req_mask : lat_mask;
    a_addr   = state == IDLE ? bus.req_addr : lat_addr;
    a_data   = state == IDLE ? bus.req_data : lat_data;
    fault    = a_addr[2:0] != 3'd0 || a_addr[63:3] >= 61'(DEPTH);
    idx      = a_addr[IW+2:3];
    rd_word  = mem[idx];
    wr_word  = rd_word;
    for (int i = 0; i < 8; i++)
      if (a_mask[i]) wr_word[8*i +: 8] = a_data[8*i +: 8];
    state_nx = state;
    cnt_nx   = cnt;
    if (take) begin
      state_nx = BUSY;
      cnt_nx   = CW'(LATENCY - 1);
    end
    if (state == BUSY) cnt_nx = cnt - 1'b1;
    if (done) state_nx = RESP;
    if (state == RESP && bus.resp_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      resp_data_q <= '0;
      resp_dexc_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (done) begin
        resp_data_q <= fault || a_wren ? 64'd0 : rd_word;
        resp_dexc_q <= fault;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (take) begin
      lat_wren <= bus.req_wren;
      lat_mask <= bus.req_mask;
      lat_addr <= bus.req_addr;
      lat_data <= bus.req_data;
    end
  end
  // Array has no reset; the rst gate keeps an aborted write from landing
  always_ff @(posedge clk) begin
    if (!rst && done && a_wren && !fault) mem[idx] <= wr_word;
  end
  assign bus.req_ready  = state == IDLE;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_dexc  = resp_dexc_q;
endmodule

// File: tb/tb_mem_action_responder.sv
// tb_mem_action_responder: directed checks of the responder at LATENCY=2 and LATENCY=1
module tb_mem_action_responder;
  logic clk, rst;
  int n_cmp, n_err;
  logic [63:0] q1 [$];
  mem_action_responder_if b0();
  mem_action_responder_if b1();
  mem_action_responder #(.DEPTH(1024), .LATENCY(2)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  mem_action_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk)
    if (!rst && b1.resp_valid && b1.resp_ready) q1.push_back(b1.resp_data);

  task automatic xact(input logic w, input logic [7:0] m, input logic [63:0] a, input logic [63:0] d,
                      output logic [63:0] rd, output logic rx, output int lat);
    int n;
    lat = -1;
    rd  = 'x;
    rx  = 1'bx;
    n   = 0;
    while (!b0.req_ready && n < 20) begin @(posedge clk); #1; n++; end
    b0.req_valid = 1'b1;
    b0.req_wren  = w;
    b0.req_mask  = m;
    b0.req_addr  = a;
    b0.req_data  = d;
    @(posedge clk); #1;
    b0.req_valid = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!b0.resp_valid && n < 20);
    if (b0.resp_valid) begin
      lat = n;
      rd  = b0.resp_data;
      rx  = b0.resp_dexc;
      b0.resp_ready = 1'b1;
      @(posedge clk); #1;
      b0.resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    n_cmp++; if (b0.req_ready !== 1'b1) begin n_err++; $display("FAIL reset req_ready: got %b want 1", b0.req_ready); end
    n_cmp++; if (b0.resp_valid !== 1'b0) begin n_err++; $display("FAIL reset resp_valid: got %b want 0", b0.resp_valid); end
    n_cmp++; if (b0.resp_data !== 64'd0) begin n_err++; $display("FAIL reset resp_data: got %h want 0", b0.resp_data); end
    n_cmp++; if (b0.resp_dexc !== 1'b0) begin n_err++; $display("FAIL reset resp_dexc: got %b want 0", b0.resp_dexc); end
    n_cmp++; if (b1.req_ready !== 1'b1) begin n_err++; $display("FAIL reset l1 req_ready: got %b want 1", b1.req_ready); end
  endtask

  task automatic test_write_read;
    logic [63:0] d; logic x; int l;
    xact(1'b1, 8'hFF, 64'h40, 64'h1122334455667788, d, x, l);
    n_cmp++; if (l !== 2) begin n_err++; $display("FAIL write latency: got %0d want 2", l); end
    n_cmp++; if (d !== 64'd0) begin n_err++; $display("FAIL write resp_data: got %h want 0", d); end
    n_cmp++; if (x !== 1'b0) begin n_err++; $display("FAIL write dexc: got %b want 0", x); end
    xact(1'b0, 8'h00, 64'h40, 64'h0, d, x, l);
    n_cmp++; if (l !== 2) begin n_err++; $display("FAIL read latency: got %0d want 2", l); end
    n_cmp++; if (d !== 64'h1122334455667788) begin n_err++; $display("FAIL read data: got %h want 1122334455667788", d); end
    n_cmp++; if (x !== 1'b0) begin n_err++; $display("FAIL read dexc: got %b want 0", x); end
  endtask

  task automatic test_masked;
    logic [63:0] d; logic x; int l;
    xact(1'b1, 8'h0F, 64'h40, 64'hAAAAAAAAAAAAAAAA, d, x, l);
    xact(1'b0, 8'hFF, 64'h40, 64'h0, d, x, l);
    n_cmp++; if (d !== 64'h11223344AAAAAAAA) begin n_err++; $display("FAIL masked read: got %h want 11223344aaaaaaaa", d); end
    xact(1'b1, 8'h00, 64'h40, 64'h0, d, x, l);
    n_cmp++; if (x !== 1'b0) begin n_err++; $display("FAIL mask0 dexc: got %b want 0", x); end
    xact(1'b0, 8'h00, 64'h40, 64'h0, d, x, l);
    n_cmp++; if (d !== 64'h11223344AAAAAAAA) begin n_err++; $display("FAIL mask0 read: got %h want 11223344aaaaaaaa", d); end
  endtask

  task automatic test_faults;
    logic [63:0] d; logic x; int l;
    xact(1'b0, 8'h00, 64'h44, 64'h0, d, x, l);
    n_cmp++; if (x !== 1'b1) begin n_err++; $display("FAIL misaligned dexc: got %b want 1", x); end
    n_cmp++; if (d !== 64'd0) begin n_err++; $display("FAIL misaligned data: got %h want 0", d); end
    xact(1'b1, 8'hFF, 64'h1FF8, 64'hCAFEF00DDEADBEEF, d, x, l);
    n_cmp++; if (x !== 1'b0) begin n_err++; $display("FAIL last word dexc: got %b want 0", x); end
    xact(1'b1, 8'hFF, 64'h2000, 64'h0123456789ABCDEF, d, x, l);
    n_cmp++; if (x !== 1'b1) begin n_err++; $display("FAIL oob write dexc: got %b want 1", x); end
    xact(1'b0, 8'h00, 64'h1FF8, 64'h0, d, x, l);
    n_cmp++; if (d !== 64'hCAFEF00DDEADBEEF) begin n_err++; $display("FAIL last word after oob: got %h want cafef00ddeadbeef", d); end
    xact(1'b1, 8'hFF, 64'h43, 64'h0, d, x, l);
    xact(1'b0, 8'h00, 64'h40, 64'h0, d, x, l);
    n_cmp++; if (d !== 64'h11223344AAAAAAAA) begin n_err++; $display("FAIL misaligned write leak: got %h want 11223344aaaaaaaa", d); end
  endtask

  task automatic test_backpressure;
    logic [63:0] d; logic x; int l, n;
    b0.req_valid = 1'b1;
    b0.req_wren  = 1'b0;
    b0.req_mask  = 8'h00;
    b0.req_addr  = 64'h40;
    @(posedge clk); #1;
    b0.req_wren  = 1'b1;
    b0.req_mask  = 8'hFF;
    b0.req_data  = 64'd0;
    n = 0;
    while (!b0.resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    n_cmp++; if (b0.resp_valid !== 1'b1) begin n_err++; $display("FAIL bp resp arrival: got %b want 1", b0.resp_valid); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (b0.resp_valid !== 1'b1) begin n_err++; $display("FAIL bp hold valid[%0d]: got %b want 1", i, b0.resp_valid); end
      n_cmp++; if (b0.resp_data !== 64'h11223344AAAAAAAA) begin n_err++; $display("FAIL bp hold data[%0d]: got %h want 11223344aaaaaaaa", i, b0.resp_data); end
      n_cmp++; if (b0.req_ready !== 1'b0) begin n_err++; $display("FAIL bp req_ready[%0d]: got %b want 0", i, b0.req_ready); end
      @(posedge clk); #1;
    end
    b0.resp_ready = 1'b1;
    b0.req_valid  = 1'b0;
    @(posedge clk); #1;
    b0.resp_ready = 1'b0;
    n_cmp++; if (b0.req_ready !== 1'b1) begin n_err++; $display("FAIL bp release req_ready: got %b want 1", b0.req_ready); end
    n_cmp++; if (b0.resp_valid !== 1'b0) begin n_err++; $display("FAIL bp release resp_valid: got %b want 0", b0.resp_valid); end
    xact(1'b0, 8'h00, 64'h40, 64'h0, d, x, l);
    n_cmp++; if (d !== 64'h11223344AAAAAAAA) begin n_err++; $display("FAIL bp ignored req: got %h want 11223344aaaaaaaa", d); end
  endtask

  task automatic test_reset_midop;
    logic [63:0] d; logic x; int l;
    xact(1'b1, 8'hFF, 64'h80, 64'h5555AAAA5555AAAA, d, x, l);
    b0.req_valid = 1'b1;
    b0.req_wren  = 1'b1;
    b0.req_mask  = 8'hFF;
    b0.req_addr  = 64'h80;
    b0.req_data  = 64'h9999999999999999;
    @(posedge clk); #1;
    b0.req_valid = 1'b0;
    n_cmp++; if (b0.req_ready !== 1'b0) begin n_err++; $display("FAIL midop busy: got %b want 0", b0.req_ready); end
    rst = 1'b1;
    #1;
    n_cmp++; if (b0.req_ready !== 1'b1) begin n_err++; $display("FAIL midop req_ready: got %b want 1", b0.req_ready); end
    n_cmp++; if (b0.resp_valid !== 1'b0) begin n_err++; $display("FAIL midop resp_valid: got %b want 0", b0.resp_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (b0.resp_valid !== 1'b0) begin n_err++; $display("FAIL midop no resp[%0d]: got %b want 0", i, b0.resp_valid); end
    end
    xact(1'b0, 8'h00, 64'h80, 64'h0, d, x, l);
    n_cmp++; if (d !== 64'h5555AAAA5555AAAA) begin n_err++; $display("FAIL midop read: got %h want 5555aaaa5555aaaa", d); end
  endtask

  task automatic test_back_to_back;
    logic        w [8]  = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic [63:0] a [8]  = '{64'h0, 64'h8, 64'h10, 64'h18, 64'h18, 64'h0, 64'h8, 64'h10};
    logic [63:0] dv [8] = '{64'h0101010101010101, 64'h0202020202020202, 64'h0303030303030303, 64'h0404040404040404, 0, 0, 0, 0};
    logic [63:0] e [8]  = '{0, 0, 0, 0, 64'h0404040404040404, 64'h0101010101010101, 64'h0202020202020202, 64'h0303030303030303};
    int n;
    q1.delete();
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (!b1.req_ready && n < 10) begin @(posedge clk); #1; n++; end
      b1.req_valid = 1'b1;
      b1.req_wren  = w[k];
      b1.req_mask  = 8'hFF;
      b1.req_addr  = a[k];
      b1.req_data  = dv[k];
      @(posedge clk); #1;
      b1.req_valid = 1'b0;
    end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (q1.size() !== 8) begin n_err++; $display("FAIL l1 resp count: got %0d want 8", q1.size()); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (k >= q1.size()) begin n_err++; $display("FAIL l1 resp[%0d]: got none want %h", k, e[k]); end
      else if (q1[k] !== e[k]) begin n_err++; $display("FAIL l1 resp[%0d]: got %h want %h", k, q1[k], e[k]); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    b0.req_valid = 1'b0; b0.req_wren = 1'b0; b0.req_mask = 8'h0; b0.req_addr = 64'h0; b0.req_data = 64'h0; b0.resp_ready = 1'b0;
    b1.req_valid = 1'b0; b1.req_wren = 1'b0; b1.req_mask = 8'h0; b1.req_addr = 64'h0; b1.req_data = 64'h0; b1.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_write_read();
    test_masked();
    test_faults();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
